// File: rtl/debug_dump_tx.sv
// debug_dump_tx: streams a halted-core snapshot (latches, registers, data memory) into the UART TX FIFO.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module debug_dump_tx #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int IF_ID_SIZE    = 32,
  parameter int ID_EX_SIZE    = 129,
  parameter int EX_MEM_SIZE   = 77,
  parameter int MEM_WB_SIZE   = 71,
  parameter int MEM_WORDS     = 16,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [IF_ID_SIZE-1:0]         i_if_id,
  input  logic [ID_EX_SIZE-1:0]         i_id_ex,
  input  logic [EX_MEM_SIZE-1:0]        i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0]        i_mem_wb,
  input  logic [NUM_REGISTERS*SIZE-1:0] i_registers,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  input  logic [SIZE-1:0]               i_mem_data,
  input  logic                          i_tx_full,
  output logic                          o_tx_wr,
  output logic [7:0]                    o_tx_data,
  output logic                          o_busy,
  output logic                          o_done
);
  localparam int IF_ID_W  = ((IF_ID_SIZE + 7) / 8) * 8;
  localparam int ID_EX_W  = ((ID_EX_SIZE + 7) / 8) * 8;
  localparam int EX_MEM_W = ((EX_MEM_SIZE + 7) / 8) * 8;
  localparam int MEM_WB_W = ((MEM_WB_SIZE + 7) / 8) * 8;
  localparam int LATCH_B  = (IF_ID_W + ID_EX_W + EX_MEM_W + MEM_WB_W) / 8;
  localparam int WB       = SIZE / 8;
  localparam int WB_L     = $clog2(WB);
  localparam int REG_B    = NUM_REGISTERS * WB;
  localparam int MEM_B    = MEM_WORDS * WB;
  localparam int LAT_LAST = LATCH_B;
  localparam int REG_LAST = LAT_LAST + REG_B;
  localparam int MEM_LAST = REG_LAST + MEM_B;
`ifdef DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = MEM_LAST + 2;
`else
  localparam int FRAME_LEN = MEM_LAST + 1;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, HDR, LATCH, REGS, MEM_RD, MEM_BYTE,
`ifdef DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t                state_q;
  logic [LATCH_B*8-1:0]  snap_q, snap_d;
  logic [CW-1:0]         ptr_q, lat_idx, reg_idx;
  logic [WB_L-1:0]       mem_sel;
  logic [SIZE-1:0]       word_q;
  logic                  wait_q, busy_q, done_q, emit, wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            lat_byte, reg_byte, mem_byte, tx_data;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign snap_d   = {MEM_WB_W'(i_mem_wb), EX_MEM_W'(i_ex_mem), ID_EX_W'(i_id_ex), IF_ID_W'(i_if_id)};
  // ptr_q counts frame bytes already written, so it is also the index of the byte on offer
  assign lat_idx  = ptr_q - CW'(1);
  assign reg_idx  = ptr_q - CW'(LAT_LAST + 1);
  assign mem_sel  = WB_L'(ptr_q - CW'(REG_LAST + 1));
  assign lat_byte = 8'(snap_q >> {lat_idx, 3'b000});
  assign reg_byte = 8'(i_registers >> {reg_idx, 3'b000});
  assign mem_byte = 8'(word_q >> {mem_sel, 3'b000});

`ifdef DUMP_CHECKSUM_EN
  assign emit    = state_q inside {HDR, LATCH, REGS, MEM_BYTE, CSUM};
  assign tx_data = state_q == HDR      ? 8'hA5 :
                   state_q == LATCH    ? lat_byte :
                   state_q == REGS     ? reg_byte :
                   state_q == MEM_BYTE ? mem_byte :
                   state_q == CSUM     ? csum_q : 8'h00;
`else
  assign emit    = state_q inside {HDR, LATCH, REGS, MEM_BYTE};
  assign tx_data = state_q == HDR      ? 8'hA5 :
                   state_q == LATCH    ? lat_byte :
                   state_q == REGS     ? reg_byte :
                   state_q == MEM_BYTE ? mem_byte : 8'h00;
`endif
  // Gating with i_rst keeps a reset cycle from leaking one last write
  assign wr         = emit && !i_tx_full && !i_rst;
  assign o_tx_wr    = wr;
  assign o_tx_data  = tx_data;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_mem_addr = addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      ptr_q   <= '0;
      word_q  <= '0;
      wait_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      if (wr) begin
        ptr_q  <= ptr_q + CW'(1);
`ifdef DUMP_CHECKSUM_EN
        csum_q <= csum_q ^ tx_data;
`endif
      end
      case (state_q)
        IDLE: if (i_start) begin
          snap_q  <= snap_d;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= HDR;
`ifdef DUMP_CHECKSUM_EN
          csum_q  <= 8'h00;
`endif
        end
        HDR:   if (wr) state_q <= LATCH;
        LATCH: if (wr && ptr_q == CW'(LAT_LAST)) state_q <= REGS;
        REGS:  if (wr && ptr_q == CW'(REG_LAST)) state_q <= MEM_RD;
        MEM_RD: begin
          wait_q <= !wait_q;
          if (wait_q) begin
            word_q  <= i_mem_data;
            state_q <= MEM_BYTE;
          end
        end
        MEM_BYTE: if (wr && &mem_sel) begin
          if (ptr_q == CW'(MEM_LAST)) begin
`ifdef DUMP_CHECKSUM_EN
            state_q <= CSUM;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            addr_q  <= '0;
`endif
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(4);
            state_q <= MEM_RD;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: if (wr) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          addr_q  <= '0;
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx: randomized frame checks of debug_dump_tx against a byte-list reference model.
module tb_debug_dump_tx;
`ifdef DUMP_CHECKSUM_EN
  localparam int FL = 234;
`else
  localparam int FL = 233;
`endif

  logic         i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_tx_full = 1'b0;
  logic [31:0]  i_if_id = '0;
  logic [128:0] i_id_ex = '0;
  logic [76:0]  i_ex_mem = '0;
  logic [70:0]  i_mem_wb = '0;
  logic [1023:0] i_registers = '0;
  logic [31:0]  o_mem_addr, i_mem_data;
  logic         o_tx_wr, o_busy, o_done;
  logic [7:0]   o_tx_data;
  logic [31:0]  mem [16];

  debug_dump_tx dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_if_id(i_if_id), .i_id_ex(i_id_ex),
    .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb), .i_registers(i_registers), .o_mem_addr(o_mem_addr),
    .i_mem_data(i_mem_data), .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) i_mem_data <= mem[o_mem_addr[5:2]];

  int n_tests = 0, n_fail = 0, cyc = 0, done_n = 0, done_cyc = 0, last_wr_cyc = 0, full_wr = 0;
  int hold_n0 = 0, hold_n1 = 0;
  bit done_busy = 1'b0;
  logic [7:0]  got[$], exp[$], ref_frame[$];
  logic [31:0] addr_trace[$];
  logic [31:0] prev_addr = '0;

  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) begin
    if (o_tx_wr) begin got.push_back(o_tx_data); last_wr_cyc = cyc; end
    if (o_tx_wr && i_tx_full) full_wr++;
    if (o_done) begin done_n++; done_cyc = cyc; done_busy = o_busy; end
    if (o_mem_addr !== prev_addr) begin addr_trace.push_back(o_mem_addr); prev_addr = o_mem_addr; end
  end

  task automatic randomize_inputs;
    i_if_id  = $urandom;
    i_id_ex  = 129'({$urandom, $urandom, $urandom, $urandom, $urandom});
    i_ex_mem = 77'({$urandom, $urandom, $urandom});
    i_mem_wb = 71'({$urandom, $urandom, $urandom});
    for (int k = 0; k < 32; k++) i_registers[k*32 +: 32] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endtask

  // Frame = header, each latch as its own zero-padded little-endian field, registers, memory words
  task automatic build_expected;
    logic [135:0] v;
    logic [7:0] x;
    exp.delete();
    exp.push_back(8'hA5);
    v = 136'(i_if_id);  for (int b = 0; b < 4; b++)  exp.push_back(v[b*8 +: 8]);
    v = 136'(i_id_ex);  for (int b = 0; b < 17; b++) exp.push_back(v[b*8 +: 8]);
    v = 136'(i_ex_mem); for (int b = 0; b < 10; b++) exp.push_back(v[b*8 +: 8]);
    v = 136'(i_mem_wb); for (int b = 0; b < 9; b++)  exp.push_back(v[b*8 +: 8]);
    for (int k = 0; k < 32; k++) for (int b = 0; b < 4; b++) exp.push_back(i_registers[k*32 + b*8 +: 8]);
    for (int i = 0; i < 16; i++) for (int b = 0; b < 4; b++) exp.push_back(mem[i][b*8 +: 8]);
`ifdef DUMP_CHECKSUM_EN
    x = 8'h00;
    foreach (exp[i]) x ^= exp[i];
    exp.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic clear_mon;
    got.delete();
    addr_trace.delete();
    done_n = 0;
    full_wr = 0;
  endtask

  task automatic do_dump(input int stall_at, input int restart_at, output bit ok);
    bit pulsed = 1'b0, stalled = 1'b0;
    clear_mon();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    for (int c = 0; c < 3000 && done_n == 0; c++) begin
      if (stall_at >= 0 && !stalled && got.size() >= stall_at) begin
        i_tx_full = 1'b1;
        hold_n0 = got.size();
        repeat (10) @(posedge i_clk);
        #1 hold_n1 = got.size();
        i_tx_full = 1'b0;
        stalled = 1'b1;
      end
      i_start = restart_at >= 0 && !pulsed && got.size() >= restart_at;
      if (i_start) pulsed = 1'b1;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    ok = done_n != 0;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    n_tests += 5;
    if (o_tx_wr !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_wr got=%b exp=0", o_tx_wr); end
    if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    if (o_done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b exp=0", o_done); end
    if (o_mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", o_mem_addr); end
    if (o_tx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_tx_data got=%h exp=0", o_tx_data); end
    i_rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    int bad = 0;
    logic [7:0] hd [5] = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
    randomize_inputs();
    i_if_id = 32'h12345678;
    build_expected();
    do_dump(-1, -1, ok);
    n_tests += 7;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout got=no_done exp=done"); end
    if (got.size() != FL) begin n_fail++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), FL); end
    for (int i = 0; i < 5; i++) if (got[i] !== hd[i]) bad++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_head got=%h %h %h %h %h exp=a5 78 56 34 12", got[0], got[1], got[2], got[3], got[4]); end
    bad = 0;
    foreach (exp[i]) if (got[i] !== exp[i]) bad++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_frame got=%0d bad bytes exp=0", bad); end
    if (done_n != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", done_n); end
    if (done_cyc != last_wr_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_wr_cyc + 1); end
    if (done_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", done_busy); end
  endtask

  task automatic test_register;
    bit ok;
    logic [7:0] rb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    randomize_inputs();
    i_registers[63:32] = 32'hDEADBEEF;
    do_dump(-1, -1, ok);
    n_tests += 5;
    if (!ok) begin n_fail++; $display("FAIL reg_timeout got=no_done exp=done"); end
    for (int i = 0; i < 4; i++)
      if (got[45+i] !== rb[i]) begin n_fail++; $display("FAIL reg_byte%0d got=%h exp=%h", 45+i, got[45+i], rb[i]); end
  endtask

  task automatic test_memory;
    bit ok;
    int bad = 0;
    logic [7:0] mb [4] = '{8'hFE, 8'hCA, 8'h00, 8'h00};
    randomize_inputs();
    mem[3] = 32'h0000CAFE;
    do_dump(-1, -1, ok);
    n_tests += 6;
    if (!ok) begin n_fail++; $display("FAIL mem_timeout got=no_done exp=done"); end
    for (int i = 0; i < 4; i++)
      if (got[181+i] !== mb[i]) begin n_fail++; $display("FAIL mem_byte%0d got=%h exp=%h", 181+i, got[181+i], mb[i]); end
    if (addr_trace.size() != 16) bad++;
    for (int i = 0; i < 15; i++) if (addr_trace[i] !== 32'(4*(i+1))) bad++;
    if (addr_trace[15] !== 32'd0) bad++;
    if (bad != 0) begin n_fail++; $display("FAIL mem_addr_steps got=%0d changes/%0d wrong exp=16/0", addr_trace.size(), bad); end
  endtask

  task automatic test_backpressure;
    bit ok1, ok2;
    int bad = 0;
    randomize_inputs();
    build_expected();
    do_dump(-1, -1, ok1);
    ref_frame = got;
    do_dump(20, -1, ok2);
    n_tests += 5;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL bp_timeout got=no_done exp=done"); end
    if (hold_n1 != hold_n0 || hold_n0 != 20) begin n_fail++; $display("FAIL bp_hold_writes got=%0d..%0d exp=20..20", hold_n0, hold_n1); end
    if (full_wr != 0) begin n_fail++; $display("FAIL bp_write_while_full got=%0d exp=0", full_wr); end
    if (got != ref_frame) begin n_fail++; $display("FAIL bp_vs_nostall got=%0d bytes exp=%0d bytes", got.size(), ref_frame.size()); end
    foreach (exp[i]) if (got[i] !== exp[i]) bad++;
    if (bad != 0 || got.size() != FL) begin n_fail++; $display("FAIL bp_frame got=%0d bad/%0d len exp=0/%0d", bad, got.size(), FL); end
  endtask

  task automatic test_restart;
    bit ok;
    int bad = 0;
    randomize_inputs();
    build_expected();
    do_dump(-1, 100, ok);
    n_tests += 3;
    if (!ok) begin n_fail++; $display("FAIL restart_timeout got=no_done exp=done"); end
    foreach (exp[i]) if (got[i] !== exp[i]) bad++;
    if (bad != 0 || got.size() != FL) begin n_fail++; $display("FAIL restart_frame got=%0d bad/%0d len exp=0/%0d", bad, got.size(), FL); end
    if (done_n != 1) begin n_fail++; $display("FAIL restart_done_count got=%0d exp=1", done_n); end
  endtask

  task automatic test_reset_mid;
    bit hit = 1'b0;
    randomize_inputs();
    clear_mon();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      if (got.size() >= 50) hit = 1'b1;
      else begin @(posedge i_clk); #1; end
    end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    n_tests += 4;
    if (!hit) begin n_fail++; $display("FAIL rstmid_reach got=%0d exp=50", got.size()); end
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
    i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    if (got.size() != 50) begin n_fail++; $display("FAIL rstmid_writes got=%0d exp=50", got.size()); end
    if (done_n != 0) begin n_fail++; $display("FAIL rstmid_done got=%0d exp=0", done_n); end
  endtask

  task automatic test_back_to_back;
    bit seen = 1'b0;
    int bad = 0;
    randomize_inputs();
    build_expected();
    clear_mon();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (o_done) seen = 1'b1;
      else begin @(posedge i_clk); #1; end
    end
    i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    n_tests += 4;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done got=%b exp=0", o_busy); end
    clear_mon();
    i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got=%b exp=1", o_busy); end
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (done_n != 0) seen = 1'b1;
      else begin @(posedge i_clk); #1; end
    end
    if (!seen) begin n_fail++; $display("FAIL b2b_timeout got=no_done exp=done"); end
    foreach (exp[i]) if (got[i] !== exp[i]) bad++;
    if (bad != 0 || got.size() != FL) begin n_fail++; $display("FAIL b2b_frame got=%0d bad/%0d len exp=0/%0d", bad, got.size(), FL); end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

`ifdef DUMP_CHECKSUM_EN
  task automatic test_checksum;
    bit ok;
    i_if_id = '0; i_id_ex = '0; i_ex_mem = '0; i_mem_wb = '0; i_registers = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    do_dump(-1, -1, ok);
    n_tests += 2;
    if (got.size() != 234) begin n_fail++; $display("FAIL csum_len got=%0d exp=234", got.size()); end
    if (got[got.size()-1] !== 8'hA5) begin n_fail++; $display("FAIL csum_byte got=%h exp=a5", got[got.size()-1]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_register();
    test_memory();
    test_backpressure();
    test_restart();
    test_reset_mid();
    test_back_to_back();
`ifdef DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
